// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and constants for the instruction-memory load controller
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_load_controller_if.sv
// rtl/imem_load_controller_if.sv - loader stream, fetch and memory port bundle
interface imem_load_controller_if #(
    parameter int PC_SIZE = 32
);
    logic               ld_start;
    logic               ld_valid;
    logic [7:0]         ld_byte;
    logic               ld_last;
    logic               ld_ready;
    logic [PC_SIZE-1:0] fetch_addr;
    logic               fetch_grant;
    logic [PC_SIZE-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_we;
    logic               cpu_run;
    logic               busy;
    logic [PC_SIZE-1:0] load_count;
    logic               err_overflow;

    // Controller side
    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last, fetch_addr,
        output ld_ready, fetch_grant, mem_addr, mem_wdata, mem_we,
               cpu_run, busy, load_count, err_overflow
    );

    // Loader / fetch / memory side
    modport master (
        output ld_start, ld_valid, ld_byte, ld_last, fetch_addr,
        input  ld_ready, fetch_grant, mem_addr, mem_wdata, mem_we,
               cpu_run, busy, load_count, err_overflow
    );

endinterface

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs little-endian bytes into 32-bit words
module imem_word_packer
    import imem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        word_done,
    output logic [31:0] word_data
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);

    logic [31:0]           lanes;
    logic [BYTE_IDX_W-1:0] byte_idx;

    // A word completes on the top lane or on the program's final byte
    assign word_done = accept && ((byte_idx == LAST_IDX) || in_last);

    // Current lanes with the incoming byte merged; unfilled lanes stay zero
    always_comb begin
        word_data = lanes;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_idx == BYTE_IDX_W'(i)) begin
                word_data[8*i +: 8] = in_byte;
            end
        end
    end

    // Lane storage and byte index; cleared after every emitted word so partial words pad with zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (clr || word_done) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            lanes    <= word_data;
            byte_idx <= byte_idx + IDX_ONE;
        end
    end

endmodule

// File: rtl/imem_load_controller.sv
// rtl/imem_load_controller.sv - clears, loads and hands over the instruction memory port
module imem_load_controller
    import imem_ctrl_pkg::*;
#(
    parameter int PC_SIZE  = 32,
    parameter int MEM_SIZE = 1024
)(
    input  logic                  clk,
    input  logic                  reset,
    imem_load_controller_if.slave bus
);

    localparam logic [PC_SIZE-1:0] MEM_LIMIT = PC_SIZE'(MEM_SIZE);
    localparam logic [PC_SIZE-1:0] ONE       = PC_SIZE'(1);

    state_t             state;
    logic [PC_SIZE-1:0] wr_ptr;
    logic [PC_SIZE-1:0] mem_addr_q;
    logic [PC_SIZE-1:0] load_count_q;
    logic [31:0]        mem_wdata_q;
    logic               mem_we_q;
    logic               cpu_run_q;
    logic               busy_q;
    logic               ld_ready_q;
    logic               err_q;
    logic               done_pending;

    logic               restart;
    logic               accept;
    logic               packer_clr;
    logic               word_done;
    logic [31:0]        word_data;

    // ld_start is ignored while the sweep runs; it wins over a same-cycle byte
    assign restart    = bus.ld_start && (state != ST_CLEAR);
    assign accept     = bus.ld_valid && ld_ready_q && !bus.ld_start;
    assign packer_clr = restart || (state == ST_IDLE);

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (packer_clr),
        .accept    (accept),
        .in_byte   (bus.ld_byte),
        .in_last   (bus.ld_last),
        .word_done (word_done),
        .word_data (word_data)
    );

    // Main FSM: sweep, wait, load words, then release the core; all port outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_CLEAR;
            wr_ptr       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b1;
            ld_ready_q   <= 1'b0;
            load_count_q <= '0;
            err_q        <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (wr_ptr != MEM_LIMIT) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_ptr;
                        mem_wdata_q <= '0;
                        wr_ptr      <= wr_ptr + ONE;
                    end else begin
                        state      <= ST_IDLE;
                        busy_q     <= 1'b0;
                        wr_ptr     <= '0;
                        mem_addr_q <= '0;
                    end
                end
                ST_IDLE: begin
                    wr_ptr       <= '0;
                    load_count_q <= '0;
                    err_q        <= 1'b0;
                    if (bus.ld_start) begin
                        state      <= ST_LOAD;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_start) begin
                        wr_ptr       <= '0;
                        load_count_q <= '0;
                        err_q        <= 1'b0;
                        done_pending <= 1'b0;
                        ld_ready_q   <= 1'b1;
                    end else if (done_pending) begin
                        // The final write cycle has just happened; release the core
                        done_pending <= 1'b0;
                        state        <= ST_RUN;
                        cpu_run_q    <= 1'b1;
                        busy_q       <= 1'b0;
                    end else if (accept) begin
                        if (word_done) begin
                            if (wr_ptr == MEM_LIMIT) begin
                                err_q <= 1'b1;
                            end else begin
                                mem_we_q     <= 1'b1;
                                mem_addr_q   <= wr_ptr;
                                mem_wdata_q  <= word_data;
                                wr_ptr       <= wr_ptr + ONE;
                                load_count_q <= load_count_q + ONE;
                            end
                        end
                        if (bus.ld_last) begin
                            ld_ready_q   <= 1'b0;
                            done_pending <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.ld_start) begin
                        state        <= ST_LOAD;
                        cpu_run_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        ld_ready_q   <= 1'b1;
                        wr_ptr       <= '0;
                        load_count_q <= '0;
                        err_q        <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Fetch owns the address only while the core runs; otherwise the controller drives it
    assign bus.mem_addr     = cpu_run_q ? bus.fetch_addr : mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.cpu_run      = cpu_run_q;
    assign bus.fetch_grant  = cpu_run_q;
    assign bus.busy         = busy_q;
    assign bus.ld_ready     = ld_ready_q;
    assign bus.load_count   = load_count_q;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// tb/tb_imem_load_controller.sv - directed bench for imem_load_controller
module tb_imem_load_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic [31:0] fetch_addr = 32'h0;

    int tests = 0;
    int fails = 0;

    logic [7:0]  prog[$];
    logic [31:0] mem0[1024];
    logic [31:0] mem1[4];
    int          we1_cnt = 0;

    always #5 clk = ~clk;

    imem_load_controller_if #(.PC_SIZE(32)) bus0();
    imem_load_controller_if #(.PC_SIZE(32)) bus1();

    assign bus0.ld_start   = ld_start;
    assign bus0.ld_valid   = ld_valid;
    assign bus0.ld_byte    = ld_byte;
    assign bus0.ld_last    = ld_last;
    assign bus0.fetch_addr = fetch_addr;
    assign bus1.ld_start   = ld_start;
    assign bus1.ld_valid   = ld_valid;
    assign bus1.ld_byte    = ld_byte;
    assign bus1.ld_last    = ld_last;
    assign bus1.fetch_addr = fetch_addr;

    imem_load_controller #(.PC_SIZE(32), .MEM_SIZE(1024)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    imem_load_controller #(.PC_SIZE(32), .MEM_SIZE(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always @(posedge clk) begin
        if (bus0.mem_we) mem0[bus0.mem_addr[9:0]] <= bus0.mem_wdata;
        if (bus1.mem_we) begin
            mem1[bus1.mem_addr[1:0]] <= bus1.mem_wdata;
            we1_cnt <= we1_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input string name, input bit do_start, input bit gaps);
        int  guard;
        bit  ok;
        ok = 1'b1;
        if (do_start) begin
            ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
        end
        foreach (prog[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            ld_valid = 1'b1;
            ld_byte  = prog[i];
            ld_last  = (i == prog.size() - 1);
            guard = 0;
            while (bus0.ld_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (bus0.ld_ready !== 1'b1) ok = 1'b0;
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_ready: ld_ready stuck low, required 1", name);
        end
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (bus0.cpu_run !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if (bus0.cpu_run !== 1'b1) begin
            fails++;
            $display("FAIL %s_run: cpu_run=%b required 1", name, bus0.cpu_run);
        end
    endtask

    task automatic sweep_check(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== i || bus0.mem_wdata !== 32'h0) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_sweep: %0d bad cycles, first at %0d (we=%b addr=%0d), required we=1 addr=i data=0",
                     name, bad, first, bus0.mem_we, bus0.mem_addr);
        end
        tick();
        tests++;
        if ({bus0.busy, bus0.cpu_run, bus0.mem_we, bus1.busy} !== 4'b0000) begin
            fails++;
            $display("FAIL %s_idle: busy/run/we/busy1=%b required 0000", name,
                     {bus0.busy, bus0.cpu_run, bus0.mem_we, bus1.busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        tests++;
        if ({bus0.busy, bus0.mem_we, bus0.cpu_run, bus0.fetch_grant, bus0.ld_ready, bus0.err_overflow} !== 6'b100000
            || bus0.mem_addr !== 32'h0 || bus0.load_count !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: busy/we/run/grant/ready/err=%b addr=%0d cnt=%0d required 100000 0 0",
                     {bus0.busy, bus0.mem_we, bus0.cpu_run, bus0.fetch_grant, bus0.ld_ready, bus0.err_overflow},
                     bus0.mem_addr, bus0.load_count);
        end
        reset = 1'b1;
        sweep_check("reset");
    endtask

    task automatic test_basic_load();
        prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_prog("basic", 1'b1, 1'b0);
        tests++;
        if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'd1 || bus0.mem_wdata !== 32'h00100093 || bus0.cpu_run !== 1'b0) begin
            fails++;
            $display("FAIL basic_last_write: we=%b addr=%0d data=%h run=%b required 1 1 00100093 0",
                     bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.cpu_run);
        end
        tick();
        tests++;
        if ({bus0.cpu_run, bus0.fetch_grant, bus0.mem_we, bus0.busy, bus0.ld_ready} !== 5'b11000) begin
            fails++;
            $display("FAIL basic_release: run/grant/we/busy/ready=%b required 11000",
                     {bus0.cpu_run, bus0.fetch_grant, bus0.mem_we, bus0.busy, bus0.ld_ready});
        end
        tests++;
        if (mem0[0] !== 32'h00500013 || mem0[1] !== 32'h00100093 || bus0.load_count !== 32'd2) begin
            fails++;
            $display("FAIL basic_image: m0=%h m1=%h cnt=%0d required 00500013 00100093 2",
                     mem0[0], mem0[1], bus0.load_count);
        end
    endtask

    task automatic test_partial_word();
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_prog("partial", 1'b1, 1'b0);
        wait_run("partial");
        tests++;
        if (mem0[0] !== 32'hDDCCBBAA || mem0[1] !== 32'h000000EE || bus0.load_count !== 32'd2) begin
            fails++;
            $display("FAIL partial_image: m0=%h m1=%h cnt=%0d required DDCCBBAA 000000EE 2",
                     mem0[0], mem0[1], bus0.load_count);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = we1_cnt;
        prog.delete();
        for (int i = 1; i <= 20; i++) prog.push_back(8'(i));
        load_prog("overflow", 1'b1, 1'b0);
        wait_run("overflow");
        tests++;
        if ((we1_cnt - base) !== 4 || bus1.err_overflow !== 1'b1 || bus1.load_count !== 32'd4 || bus1.cpu_run !== 1'b1) begin
            fails++;
            $display("FAIL overflow_small: writes=%0d err=%b cnt=%0d run=%b required 4 1 4 1",
                     we1_cnt - base, bus1.err_overflow, bus1.load_count, bus1.cpu_run);
        end
        tests++;
        if (mem1[0] !== 32'h04030201 || mem1[1] !== 32'h08070605 || mem1[2] !== 32'h0C0B0A09 || mem1[3] !== 32'h100F0E0D) begin
            fails++;
            $display("FAIL overflow_image: %h %h %h %h required 04030201 08070605 0C0B0A09 100F0E0D",
                     mem1[0], mem1[1], mem1[2], mem1[3]);
        end
        tests++;
        if (bus0.err_overflow !== 1'b0 || bus0.load_count !== 32'd5 || mem0[4] !== 32'h14131211) begin
            fails++;
            $display("FAIL overflow_large: err=%b cnt=%0d m4=%h required 0 5 14131211",
                     bus0.err_overflow, bus0.load_count, mem0[4]);
        end
    endtask

    task automatic test_run_reload();
        fetch_addr = 32'd7;
        #1;
        tests++;
        if (bus0.mem_addr !== 32'd7 || bus0.mem_we !== 1'b0 || bus1.mem_addr !== 32'd7) begin
            fails++;
            $display("FAIL run_fetch: addr=%0d we=%b addr1=%0d required 7 0 7",
                     bus0.mem_addr, bus0.mem_we, bus1.mem_addr);
        end
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tests++;
        if ({bus0.cpu_run, bus0.fetch_grant, bus0.busy, bus0.ld_ready, bus1.err_overflow} !== 5'b00110) begin
            fails++;
            $display("FAIL reload_start: run/grant/busy/ready/err1=%b required 00110",
                     {bus0.cpu_run, bus0.fetch_grant, bus0.busy, bus0.ld_ready, bus1.err_overflow});
        end
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_prog("reload", 1'b0, 1'b0);
        tests++;
        if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'd0 || bus0.mem_wdata !== 32'h44332211) begin
            fails++;
            $display("FAIL reload_write: we=%b addr=%0d data=%h required 1 0 44332211",
                     bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
        end
        wait_run("reload");
        tests++;
        if (mem0[1] !== 32'h08070605 || bus0.load_count !== 32'd1) begin
            fails++;
            $display("FAIL reload_keep: m1=%h cnt=%0d required 08070605 1", mem0[1], bus0.load_count);
        end
        fetch_addr = 32'd0;
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = 8'hA1;
        tick();
        ld_byte  = 8'hA2;
        tick();
        ld_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({bus0.busy, bus0.mem_we, bus0.cpu_run, bus0.fetch_grant, bus0.ld_ready, bus0.err_overflow} !== 6'b100000
            || bus0.mem_addr !== 32'h0 || bus0.load_count !== 32'h0) begin
            fails++;
            $display("FAIL midload_reset: busy/we/run/grant/ready/err=%b addr=%0d cnt=%0d required 100000 0 0",
                     {bus0.busy, bus0.mem_we, bus0.cpu_run, bus0.fetch_grant, bus0.ld_ready, bus0.err_overflow},
                     bus0.mem_addr, bus0.load_count);
        end
        tick();
        reset = 1'b1;
        sweep_check("midload");
    endtask

    task automatic test_gaps();
        prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_prog("gaps", 1'b1, 1'b1);
        wait_run("gaps");
        tests++;
        if (mem0[0] !== 32'h00500013 || mem0[1] !== 32'h00100093 || mem0[2] !== 32'h0 || bus0.load_count !== 32'd2) begin
            fails++;
            $display("FAIL gaps_image: m0=%h m1=%h m2=%h cnt=%0d required 00500013 00100093 0 2",
                     mem0[0], mem0[1], mem0[2], bus0.load_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_word();
        test_overflow();
        test_run_reload();
        test_reset_mid_load();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
